// File: rtl/cache_pkg.sv
// Shared types and sizing for the L1 data cache and its L2 request channel.
package cache_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned INDEX_BITS = 6;
    localparam int unsigned TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int unsigned NUM_LINES  = 1 << INDEX_BITS;
    localparam int unsigned CNT_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        DONE      = 2'd3
    } state_t;

    // L2 request fields, in the order the L2 controller expects them.
    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } l2_req_t;

    // Single write port into the tag/data array. wr_data gates the tag and
    // data update; valid/dirty are always written when en is set.
    typedef struct packed {
        logic                  en;
        logic                  wr_data;
        logic                  valid;
        logic                  dirty;
        logic [INDEX_BITS-1:0] idx;
        logic [TAG_BITS-1:0]   tag;
        logic [DATA_WIDTH-1:0] data;
    } arr_wr_t;

    // Word-aligned line address from a tag and an index.
    function automatic logic [ADDR_WIDTH-1:0] line_addr(
        input logic [TAG_BITS-1:0]   tag,
        input logic [INDEX_BITS-1:0] idx
    );
        return {tag, idx, 2'b00};
    endfunction

endpackage

// File: rtl/l1_dcache_ctrl_if.sv
// M-stage access and L2 request/ready signals of the L1 data cache.
// master = cache controller, slave = pipeline plus L2 controller.
interface l1_dcache_ctrl_if;
    import cache_pkg::*;

    logic                  MemReadM;
    logic                  MemWriteM;
    logic [ADDR_WIDTH-1:0] ALUResultM;
    logic [DATA_WIDTH-1:0] WriteDataM;
    logic [DATA_WIDTH-1:0] ReadDataM;
    logic                  CacheWait;

    logic                  L2Req;
    logic                  L2WE;
    logic [ADDR_WIDTH-1:0] L2Addr;
    logic [DATA_WIDTH-1:0] L2WData;
    logic [DATA_WIDTH-1:0] L2RData;
    logic                  L2Ready;

    modport master (
        input  MemReadM, MemWriteM, ALUResultM, WriteDataM, L2RData, L2Ready,
        output ReadDataM, CacheWait, L2Req, L2WE, L2Addr, L2WData
    );

    modport slave (
        output MemReadM, MemWriteM, ALUResultM, WriteDataM, L2RData, L2Ready,
        input  ReadDataM, CacheWait, L2Req, L2WE, L2Addr, L2WData
    );

endinterface

// File: rtl/dcache_tag_data_array.sv
// Direct-mapped line storage: combinational read, one write port.
// Valid/dirty bits reset; tags and data do not.
module dcache_tag_data_array
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  arr_wr_t               wr
);

    logic [NUM_LINES-1:0]  valid_q;
    logic [NUM_LINES-1:0]  dirty_q;
    logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_q [NUM_LINES];

    // Line state bits, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr.en) begin
            valid_q[wr.idx] <= wr.valid;
            dirty_q[wr.idx] <= wr.dirty;
        end
    end

    // Tag and data storage, no reset.
    always_ff @(posedge clk) begin
        if (wr.en && wr.wr_data) begin
            tag_q[wr.idx]  <= wr.tag;
            data_q[wr.idx] <= wr.data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 data cache controller.
// Hits complete in the access cycle; misses stall via CacheWait while the
// victim is written back and the line refilled from L2.
module l1_dcache_ctrl
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    l1_dcache_ctrl_if.master     bus,
    output logic [CNT_WIDTH-1:0] HitCount,
    output logic [CNT_WIDTH-1:0] MissCount
);

    state_t                state_q, state_d;
    l2_req_t               l2_q, l2_d;
    arr_wr_t               arr_wr;
    arr_wr_t               wr_merge, wr_clean, wr_fill;
    l2_req_t               req_wb, req_fill;

    logic [INDEX_BITS-1:0] addr_idx;
    logic [TAG_BITS-1:0]   addr_tag;
    logic                  rd_valid, rd_dirty;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;

    logic access, is_store, hit;
    logic cache_wait, hit_inc, miss_inc;
    logic unused_addr_bits;

    assign addr_idx         = bus.ALUResultM[INDEX_BITS+1:2];
    assign addr_tag         = bus.ALUResultM[ADDR_WIDTH-1:INDEX_BITS+2];
    assign unused_addr_bits = ^bus.ALUResultM[1:0];

    assign access   = bus.MemReadM | bus.MemWriteM;
    assign is_store = bus.MemWriteM;
    assign hit      = rd_valid && (rd_tag == addr_tag);

    dcache_tag_data_array u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (addr_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr       (arr_wr)
    );

    // Candidate array writes and L2 requests for the FSM to pick from.
    assign wr_merge = '{en: 1'b1, wr_data: 1'b1, valid: 1'b1, dirty: 1'b1,
                        idx: addr_idx, tag: addr_tag, data: bus.WriteDataM};
    assign wr_clean = '{en: 1'b1, wr_data: 1'b0, valid: 1'b1, dirty: 1'b0,
                        idx: addr_idx, tag: rd_tag, data: rd_data};
    assign wr_fill  = '{en: 1'b1, wr_data: 1'b1, valid: 1'b1, dirty: 1'b0,
                        idx: addr_idx, tag: addr_tag, data: bus.L2RData};
    assign req_wb   = '{req: 1'b1, we: 1'b1,
                        addr: line_addr(rd_tag, addr_idx), wdata: rd_data};
    assign req_fill = '{req: 1'b1, we: 1'b0,
                        addr: {bus.ALUResultM[ADDR_WIDTH-1:2], 2'b00},
                        wdata: '0};

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state, array write, L2 request and stall decode.
    always_comb begin
        state_d    = state_q;
        l2_d       = l2_q;
        arr_wr     = '0;
        cache_wait = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (hit) begin
                        hit_inc = 1'b1;
                        if (is_store) arr_wr = wr_merge;
                    end else begin
                        cache_wait = 1'b1;
                        miss_inc   = 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state_d = WRITEBACK;
                            l2_d    = req_wb;
                        end else begin
                            state_d = ALLOCATE;
                            l2_d    = req_fill;
                        end
                    end
                end
            end
            WRITEBACK: begin
                cache_wait = 1'b1;
                if (bus.L2Ready) begin
                    arr_wr  = wr_clean;
                    state_d = ALLOCATE;
                    l2_d    = req_fill;
                end
            end
            ALLOCATE: begin
                cache_wait = 1'b1;
                if (bus.L2Ready) begin
                    arr_wr   = wr_fill;
                    state_d  = DONE;
                    l2_d.req = 1'b0;
                end
            end
            DONE: begin
                if (access && is_store) arr_wr = wr_merge;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered L2 request, held until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) l2_q <= '0;
        else      l2_q <= l2_d;
    end

    // Saturating hit/miss counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            HitCount  <= '0;
            MissCount <= '0;
        end else begin
            if (hit_inc && (HitCount != '1))
                HitCount <= HitCount + CNT_WIDTH'(1);
            if (miss_inc && (MissCount != '1))
                MissCount <= MissCount + CNT_WIDTH'(1);
        end
    end

    assign bus.L2Req     = l2_q.req;
    assign bus.L2WE      = l2_q.we;
    assign bus.L2Addr    = l2_q.addr;
    assign bus.L2WData   = l2_q.wdata;
    assign bus.CacheWait = rst & cache_wait;
    assign bus.ReadDataM = rst ? rd_data : '0;

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Directed bench for l1_dcache_ctrl with a small cache model, an L2
// responder with programmable latency and a scoreboard of L2 requests and
// load data.
module tb_l1_dcache_ctrl;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] HitCount, MissCount;

    l1_dcache_ctrl_if bus();

    l1_dcache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .HitCount  (HitCount),
        .MissCount (MissCount)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } l2_exp_t;

    l2_exp_t     l2_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] l2_mem [logic [31:0]];
    int          l2_lat     = 3;
    bit          hold_ready = 1'b0;
    int          req_cyc    = 0;

    bit          mv [64];
    bit          md [64];
    logic [23:0] mt [64];
    logic [31:0] mdat [64];
    int          exp_hits   = 0;
    int          exp_misses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop the expected request and answer it.
    task automatic l2_accept();
        l2_exp_t e;
        if (l2_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL l2_req: observed unexpected request addr=%h we=%b expected none",
                   bus.L2Addr, bus.L2WE);
            bus.L2RData = 32'h0;
        end else begin
            e = l2_q.pop_front();
            check("l2_we", 32'(bus.L2WE), 32'(e.we));
            check("l2_addr", bus.L2Addr, e.addr);
            if (e.we) begin
                check("l2_wdata", bus.L2WData, e.wdata);
                l2_mem[bus.L2Addr] = bus.L2WData;
            end else begin
                bus.L2RData = l2_mem.exists(bus.L2Addr) ? l2_mem[bus.L2Addr] : 32'h0;
            end
        end
    endtask

    // L2 responder: ready on the l2_lat-th cycle of each request, or always when hold_ready.
    always begin
        @(negedge clk);
        if (!rst || !bus.L2Req) begin
            req_cyc     = 0;
            bus.L2Ready = hold_ready;
        end else begin
            req_cyc++;
            if (hold_ready || req_cyc >= l2_lat) begin
                l2_accept();
                bus.L2Ready = 1'b1;
                @(posedge clk);
                #1;
                req_cyc     = 0;
                bus.L2Ready = hold_ready;
            end
        end
    end

    // One access: update the model, push expectations, drive, wait and check.
    task automatic access(input bit is_load, input bit is_store,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input string tag);
        logic [5:0]  idx;
        logic [23:0] t;
        logic [31:0] fa, fill, exp_rd;
        int          n, exp_wait, waited;
        bit          done;
        idx      = addr[7:2];
        t        = addr[31:8];
        n        = hold_ready ? 1 : l2_lat;
        waited   = 0;
        done     = 1'b0;
        if (mv[idx] && mt[idx] == t) begin
            exp_hits++;
            exp_wait = 0;
        end else begin
            exp_misses++;
            exp_wait = 1 + n;
            if (mv[idx] && md[idx]) begin
                l2_q.push_back('{1'b1, {mt[idx], idx, 2'b00}, mdat[idx]});
                exp_wait += n;
            end
            fa   = {addr[31:2], 2'b00};
            fill = l2_mem.exists(fa) ? l2_mem[fa] : 32'h0;
            l2_q.push_back('{1'b0, fa, 32'h0});
            mv[idx]   = 1'b1;
            mt[idx]   = t;
            md[idx]   = 1'b0;
            mdat[idx] = fill;
        end
        if (is_store) begin
            mdat[idx] = wdata;
            md[idx]   = 1'b1;
        end else begin
            rd_q.push_back(mdat[idx]);
        end

        bus.MemReadM   = is_load;
        bus.MemWriteM  = is_store;
        bus.ALUResultM = addr;
        bus.WriteDataM = wdata;
        while (!done && waited < 60) begin
            @(negedge clk);
            if (bus.CacheWait) begin
                waited++;
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_wait"}, 32'(waited), 32'(exp_wait));
        check({tag, "_l2req_off"}, 32'(bus.L2Req), 32'd0);
        if (!is_store) begin
            exp_rd = rd_q.pop_front();
            check({tag, "_rdata"}, bus.ReadDataM, exp_rd);
        end
        @(posedge clk);
        #1;
        bus.MemReadM  = 1'b0;
        bus.MemWriteM = 1'b0;
        check({tag, "_hits"}, HitCount, 32'(exp_hits));
        check({tag, "_misses"}, MissCount, 32'(exp_misses));
        check({tag, "_l2_drained"}, 32'(l2_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        l2_mem[32'h100] = 32'hDEADBEEF;
        l2_mem[32'h200] = 32'hCAFEF00D;
        bus.L2RData     = 32'h0;

        // Reset with a load presented: outputs must stay quiet.
        rst            = 1'b0;
        bus.MemReadM   = 1'b1;
        bus.MemWriteM  = 1'b0;
        bus.ALUResultM = 32'h100;
        bus.WriteDataM = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cache_wait", 32'(bus.CacheWait), 32'd0);
        check("rst_rdata", bus.ReadDataM, 32'd0);
        check("rst_l2req", 32'(bus.L2Req), 32'd0);
        check("rst_l2we", 32'(bus.L2WE), 32'd0);
        check("rst_l2addr", bus.L2Addr, 32'd0);
        check("rst_l2wdata", bus.L2WData, 32'd0);
        check("rst_hits", HitCount, 32'd0);
        check("rst_misses", MissCount, 32'd0);
        bus.MemReadM = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        access(1'b1, 1'b0, 32'h100, 32'h0, "ld100_miss");
        access(1'b1, 1'b0, 32'h100, 32'h0, "ld100_hit");
        access(1'b0, 1'b1, 32'h100, 32'h12345678, "st100_hit");
        access(1'b1, 1'b0, 32'h200, 32'h0, "ld200_dirty_miss");
        access(1'b0, 1'b1, 32'h304, 32'hA5A50001, "st304_miss");
        access(1'b1, 1'b0, 32'h304, 32'h0, "ld304_hit");
        access(1'b1, 1'b1, 32'h304, 32'h0BADF00D, "rdwr304_store");
        access(1'b1, 1'b0, 32'h304, 32'h0, "ld304_after_rdwr");

        // L2Ready held high: minimum miss latency.
        hold_ready = 1'b1;
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 32'h400, 32'h0, "ld400_min_clean");
        access(1'b0, 1'b1, 32'h400, 32'h77778888, "st400_hit");
        access(1'b1, 1'b0, 32'h100, 32'h0, "ld100_min_dirty");
        access(1'b1, 1'b0, 32'h100, 32'h0, "ld100_hit_ready_high");
        hold_ready = 1'b0;
        l2_lat     = 5;
        @(posedge clk);
        #1;

        // Reset in the middle of ALLOCATE.
        bus.MemReadM   = 1'b1;
        bus.MemWriteM  = 1'b0;
        bus.ALUResultM = 32'h500;
        @(posedge clk);
        @(negedge clk);
        check("midrst_l2req_before", 32'(bus.L2Req), 32'd1);
        check("midrst_wait_before", 32'(bus.CacheWait), 32'd1);
        check("midrst_l2addr_before", bus.L2Addr, 32'h500);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_l2req", 32'(bus.L2Req), 32'd0);
        check("midrst_cache_wait", 32'(bus.CacheWait), 32'd0);
        check("midrst_rdata", bus.ReadDataM, 32'd0);
        check("midrst_hits", HitCount, 32'd0);
        check("midrst_misses", MissCount, 32'd0);
        for (int i = 0; i < 64; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
        exp_hits     = 0;
        exp_misses   = 0;
        bus.MemReadM = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        access(1'b1, 1'b0, 32'h100, 32'h0, "ld100_after_rst");
        access(1'b1, 1'b0, 32'h100, 32'h0, "ld100_hit_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
